// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified I/D memory port arbiter.
// Holds the FSM state encoding, default bus widths and full byte mask.
package rv_mem_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  localparam logic [DEF_DW/8-1:0] BE_FULL = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between fetch, data stage, memory and the port arbiter.
// slave: arbiter view; master: requesters plus memory (environment).
interface mem_port_arbiter_if
  import rv_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_ack;
  logic [DW-1:0]   if_rdata;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_ack;
  logic [DW-1:0]   d_rdata;

  logic            stall_if;
  logic            stall_mem;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr,
    input  d_wdata, d_be,
    input  mem_ready, mem_rdata,
    output if_ack, if_rdata,
    output d_ack, d_rdata,
    output stall_if, stall_mem,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr,
    output d_wdata, d_be,
    output mem_ready, mem_rdata,
    input  if_ack, if_rdata,
    input  d_ack, d_rdata,
    input  stall_if, stall_mem,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to fetch or data stage, one at a time.
// Ports: clk, rst (async, active high), bus (slave side of the bundle).
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_LIMIT);

  arb_state_t    state;
  arb_state_t    state_n;
  logic [CW-1:0] starve_cnt;
  logic          grant_if;
  logic          grant_d;
  logic          busy;
  logic          done;
  logic          owner_d;
  logic          if_ack_c;
  logic          d_ack_c;

  logic [AW-1:0] addr_n;
  logic          we_n;
  logic [DW-1:0] wdata_n;
  logic [BW-1:0] be_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // D wins a tie unless IF has waited out its starve budget.
  always_comb begin
    state_n  = state;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.d_req &&
            !(bus.if_req && starve_cnt == CMAX)) begin
          grant_d = 1'b1;
          state_n = ST_BUSY_D;
        end else if (bus.if_req) begin
          grant_if = 1'b1;
          state_n  = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (bus.mem_ready) begin
          state_n = ST_RESP;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_BUSY_IF) ||
               (state == ST_BUSY_D);
    done     = busy && bus.mem_ready;
    if_ack_c = (state == ST_RESP) && !owner_d;
    d_ack_c  = (state == ST_RESP) && owner_d;
    addr_n   = bus.d_addr;
    we_n     = bus.d_we;
    wdata_n  = bus.d_wdata;
    be_n     = bus.d_be;
    if (grant_if) begin
      addr_n  = bus.if_addr;
      we_n    = 1'b0;
      wdata_n = '0;
      be_n    = '1;
    end
  end

  assign bus.mem_req   = busy;
  assign bus.if_ack    = if_ack_c;
  assign bus.d_ack     = d_ack_c;
  assign bus.stall_if  = bus.if_req && !if_ack_c;
  assign bus.stall_mem = bus.d_req && !d_ack_c;

  // Request fields are latched once at grant and held for the whole
  // transaction, so requesters may change inputs after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      owner_d       <= 1'b0;
    end else begin
      if (grant_if || grant_d) begin
        bus.mem_we    <= we_n;
        bus.mem_addr  <= addr_n;
        bus.mem_wdata <= wdata_n;
        bus.mem_be    <= be_n;
        owner_d       <= grant_d;
      end
      if (done) begin
        if (owner_d) begin
          bus.d_rdata <= bus.mem_rdata;
        end else begin
          bus.if_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && bus.if_req &&
                 starve_cnt != CMAX) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule
